// File: rtl/mc_alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_CLR = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mc_alu_mul.sv
// Unsigned W x W shift-add multiplier, one partial product per cycle.
// Latency: valid on the W-th cycle after load; prod is the final sum while valid is high.
// Backpressure: none; load restarts the operation, caller must hold off until done.
module mc_alu_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic [2*W-1:0] prod,
  output logic           valid
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // Iteration state: load primes the operands, then one shift-add step per cycle until cnt drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(W);
    end else if (cnt != '0) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // The last step's sum is exposed combinationally so the consumer can register it on the same edge.
  assign busy  = (cnt != '0);
  assign valid = (cnt == CW'(1));
  assign prod  = acc_nxt;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with NZCV flags; MUL uses a shift-add unit when MC_ALU_MUL_EN is defined.
// Latency: 1 cycle for all ops (and for MUL without MC_ALU_MUL_EN); W+1 cycles for MUL with it.
// Backpressure: start is only sampled in IDLE; requests while busy/done are dropped.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         set_flags,
  input  logic [W-1:0] input1,
  input  logic [W-1:0] input2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic [W-1:0] out_hi,
  output logic         Negative,
  output logic         Zero,
  output logic         CarryOut,
  output logic         overflow
);

  state_e       state;
  state_e       state_nxt;
  op_e          op_c;
  logic         idle_go;
  logic         defer;
  logic         mul_valid;
  logic [W:0]   sum;
  logic [W-1:0] b_neg;
  logic [W-1:0] res;
  logic         c_res;
  logic         v_res;

  assign op_c    = op_e'(op);
  assign idle_go = (state == ST_IDLE) && start;

`ifdef MC_ALU_MUL_EN
  logic           mul_busy;
  logic [2*W-1:0] mul_prod;
  logic           sf_q;

  mc_alu_mul #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .load  (idle_go && defer),
    .a     (input1),
    .b     (input2),
    .busy  (mul_busy),
    .prod  (mul_prod),
    .valid (mul_valid)
  );

  assign defer = (op_c == OP_MUL);
  assign busy  = mul_busy;
`else
  // Without the multiplier MUL completes in one cycle through the CLR path.
  assign defer     = 1'b0;
  assign mul_valid = 1'b0;
  assign busy      = 1'b0;
`endif

  assign done = (state == ST_DONE);

  // Single-cycle result and flags; subtraction overflow uses the MSB of the two's-complement negation.
  always_comb begin
    sum   = '0;
    res   = '0;
    c_res = 1'b0;
    v_res = 1'b0;
    b_neg = ~input2 + {{(W-1){1'b0}}, 1'b1};
    case (op_c)
      OP_ADD: begin
        sum   = {1'b0, input1} + {1'b0, input2};
        res   = sum[W-1:0];
        c_res = sum[W];
        v_res = (input1[W-1] == input2[W-1]) && (res[W-1] != input1[W-1]);
      end
      OP_SUB, OP_CMP: begin
        sum   = {1'b0, input1} + {1'b0, ~input2} + {{W{1'b0}}, 1'b1};
        res   = sum[W-1:0];
        c_res = sum[W];
        v_res = (input1[W-1] == b_neg[W-1]) && (res[W-1] != input1[W-1]);
      end
      OP_AND:  res = input1 & input2;
      OP_ORR:  res = input1 | input2;
      OP_EOR:  res = input1 ^ input2;
      default: res = '0;
    endcase
  end

  // Next-state: IDLE dispatches, MUL waits for the multiplier's last step, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = defer ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_valid) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, result and flag registers; results land on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      out      <= '0;
      out_hi   <= '0;
      Negative <= 1'b0;
      Zero     <= 1'b0;
      CarryOut <= 1'b0;
      overflow <= 1'b0;
`ifdef MC_ALU_MUL_EN
      sf_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (idle_go && !defer) begin
        // CMP only touches flags; the previous result stays visible.
        if (op_c != OP_CMP) begin
          out    <= res;
          out_hi <= '0;
        end
        if (set_flags || (op_c == OP_CMP)) begin
          Negative <= res[W-1];
          Zero     <= (res == '0);
          CarryOut <= c_res;
          overflow <= v_res;
        end
      end
`ifdef MC_ALU_MUL_EN
      if (idle_go && defer) sf_q <= set_flags;
      if ((state == ST_MUL) && mul_valid) begin
        out    <= mul_prod[W-1:0];
        out_hi <= mul_prod[2*W-1:W];
        if (sf_q) begin
          Negative <= mul_prod[W-1];
          Zero     <= (mul_prod[W-1:0] == '0);
          CarryOut <= (mul_prod[2*W-1:W] != '0);
          overflow <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;
  import mc_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic         set_flags;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         Negative;
  logic         Zero;
  logic         CarryOut;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    int           lat;
    int           nbusy;
  } exp_t;

  exp_t sb[$];

  // Reference architectural state.
  logic [W-1:0] m_out, m_hi;
  logic         m_n, m_z, m_c, m_v;

  always #5 clk = ~clk;

  mc_alu #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .set_flags (set_flags),
    .input1    (input1),
    .input2    (input2),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .out_hi    (out_hi),
    .Negative  (Negative),
    .Zero      (Zero),
    .CarryOut  (CarryOut),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_hi = '0;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  // Compute expected result from the opcode definitions and push it to the scoreboard.
  task automatic model(input logic [2:0] o, input logic sf, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]     s;
    logic [W-1:0]   r, hi, bn;
    logic           c, v;
    logic [2*W-1:0] p;
    int             sa, sb_i;
    exp_t           e;
    r = '0; hi = '0; c = 1'b0; v = 1'b0;
    e.lat = 1; e.nbusy = 0;
    case (o)
      OP_ADD: begin
        s    = (W+1)'(a) + (W+1)'(b);
        r    = s[W-1:0];
        c    = s[W];
        sa   = int'($signed(a));
        sb_i = int'($signed(b));
        v    = ((sa + sb_i) > 127) || ((sa + sb_i) < -128);
      end
      OP_SUB, OP_CMP: begin
        bn = ~b;
        s  = (W+1)'(a) + (W+1)'(bn) + (W+1)'(1);
        r  = s[W-1:0];
        c  = s[W];
        bn = bn + 8'd1;
        v  = (a[W-1] == bn[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_EOR: r = a ^ b;
      OP_MUL: begin
`ifdef MC_ALU_MUL_EN
        p  = (2*W)'(a) * (2*W)'(b);
        r  = p[W-1:0];
        hi = p[2*W-1:W];
        c  = (hi != '0);
        e.lat   = W + 1;
        e.nbusy = W;
`else
        p = '0;
        r = p[W-1:0];
`endif
      end
      default: r = '0;
    endcase
    if (o != OP_CMP) begin
      m_out = r;
      m_hi  = hi;
    end
    if (sf || (o == OP_CMP)) begin
      m_n = r[W-1];
      m_z = (r == '0);
      m_c = c;
      m_v = v;
    end
    e.out = m_out; e.hi = m_hi;
    e.n = m_n; e.z = m_z; e.c = m_c; e.v = m_v;
    sb.push_back(e);
  endtask

  // Issue one command, wait (bounded) for done, then pop and compare.
  task automatic run(input string tag, input logic [2:0] o, input logic sf,
                     input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int   lat, nb;
    exp_t e;
    model(o, sf, a, b);
    @(negedge clk);
    op = o; set_flags = sf; input1 = a; input2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = noise;
    if (noise) begin
      op = OP_ADD; set_flags = 1'b1; input1 = 8'h11; input2 = 8'h22;
    end
    lat = 0; nb = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) nb++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".busy_cycles"}, nb, e.nbusy);
    chk({tag, ".out"}, out, e.out);
    chk({tag, ".out_hi"}, out_hi, e.hi);
    chk({tag, ".N"}, Negative, e.n);
    chk({tag, ".Z"}, Zero, e.z);
    chk({tag, ".C"}, CarryOut, e.c);
    chk({tag, ".V"}, overflow, e.v);
    @(posedge clk); #1;
    chk({tag, ".done_one_cycle"}, done, 1'b0);
  endtask

  // Assert reset together with a start request and confirm everything clears with no done pulse.
  task automatic reset_check(input string tag);
    int pulses;
    op = OP_ADD; set_flags = 1'b1; input1 = 8'h7F; input2 = 8'h01;
    start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".out"}, out, m_out);
    chk({tag, ".out_hi"}, out_hi, m_hi);
    chk({tag, ".flags"}, {Negative, Zero, CarryOut, overflow}, {m_n, m_z, m_c, m_v});
    reset = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk({tag, ".no_done"}, pulses, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; set_flags = 1'b0; input1 = '0; input2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.out", out, m_out);
    chk("reset.out_hi", out_hi, m_hi);
    chk("reset.flags", {Negative, Zero, CarryOut, overflow}, {m_n, m_z, m_c, m_v});
    reset = 1'b0;
    @(posedge clk); #1;

    run("add_7f_01",   OP_ADD, 1'b1, 8'h7F, 8'h01, 1'b0);
    run("sub_05_05",   OP_SUB, 1'b1, 8'h05, 8'h05, 1'b0);
    run("and_noflags", OP_AND, 1'b0, 8'hF0, 8'h0F, 1'b0);
    run("add_12",      OP_ADD, 1'b0, 8'h12, 8'h00, 1'b0);
    run("cmp_03_07",   OP_CMP, 1'b0, 8'h03, 8'h07, 1'b0);
    run("sub_b80",     OP_SUB, 1'b1, 8'h00, 8'h80, 1'b0);
    run("sub_b00",     OP_SUB, 1'b1, 8'h33, 8'h00, 1'b0);
    run("orr",         OP_ORR, 1'b1, 8'hA5, 8'h5A, 1'b0);
    run("eor",         OP_EOR, 1'b1, 8'hFF, 8'h0F, 1'b0);
    run("add_carry",   OP_ADD, 1'b1, 8'hC0, 8'hC0, 1'b0);
    run("clr",         OP_CLR, 1'b1, 8'h5A, 8'hA5, 1'b0);
    run("cmp_eq",      OP_CMP, 1'b1, 8'h44, 8'h44, 1'b1);

`ifdef MC_ALU_MUL_EN
    run("mul_ff_ff",   OP_MUL, 1'b1, 8'hFF, 8'hFF, 1'b1);
    run("mul_noflags", OP_MUL, 1'b0, 8'h0D, 8'h0B, 1'b0);
    // Abort a multiply in its fourth busy cycle.
    @(negedge clk);
    op = OP_MUL; set_flags = 1'b1; input1 = 8'h0D; input2 = 8'h0B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.busy_before", busy, 1'b1);
    reset_check("abort");
`else
    run("mul_nomul",   OP_MUL, 1'b1, 8'h10, 8'h10, 1'b0);
    reset_check("midrun_reset");
`endif

    run("add_after_rst", OP_ADD, 1'b1, 8'h40, 8'h40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
